sme_param_engine: RTL

//  Parametrised string-match engine; successor of the fixed 32-char/8-char SME.

---
 rtl/sme_param_engine_if.sv | 23 ++
 rtl/sme_param_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sme_param_engine_if.sv
// Char-load bus into the string-match engine plus its result strobe.
// Master is the host/collector side; slave is the engine.
interface sme_param_engine_if #(
    parameter int CHAR_W = 8,
    parameter int IDX_W  = 5
);
    logic [CHAR_W-1:0] chardata;
    logic              isstring;
    logic              ispattern;
    logic              valid;
    logic              match;
    logic [IDX_W-1:0]  match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index
    );
endinterface

// File: rtl/sme_param_engine.sv
// String-match engine: buffers a string then patterns, reports the lowest-index match. SME_WILDCARD_EN adds '.', '^', '$'.
// Latency: at most str_len-blen+2 cycles from last pattern char to the one-cycle valid strobe.
// No backpressure: a new string/pattern load aborts any search in flight.
module sme_param_engine #(
    parameter int CHAR_W  = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = $clog2(STR_MAX)
) (
    input logic               clk,
    input logic               reset,
    sme_param_engine_if.slave bus
);
    localparam int SL_W = $clog2(STR_MAX + 1);
    localparam int PL_W = $clog2(PAT_MAX + 1);
    localparam int PI_W = $clog2(PAT_MAX);
`ifdef SME_WILDCARD_EN
    localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
    localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
    localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
    localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);
`endif

    typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

    state_t            state_q, state_d;
    logic [CHAR_W-1:0] str_q [STR_MAX];
    logic [CHAR_W-1:0] str_d [STR_MAX];
    logic [SL_W-1:0]   str_len_q, str_len_d;
    logic [CHAR_W-1:0] pat_q [PAT_MAX];
    logic [CHAR_W-1:0] pat_d [PAT_MAX];
    logic [PL_W-1:0]   pat_len_q, pat_len_d;
    logic [SL_W-1:0]   s_q, s_d;
    logic              isstring_q, ispattern_q;
    logic              valid_q, valid_d;
    logic              match_q, match_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    int                cand, blen, slen, plen;
    logic              anc_s, anc_e, hit, exhausted;
    logic [CHAR_W-1:0] pc, sc;

    // The falling-edge cycle of ispattern already tests candidate 0.
    always_comb begin
        cand  = (state_q == SEARCH) ? int'(s_q) : 0;
        slen  = int'(str_len_q);
        plen  = int'(pat_len_q);
        anc_s = 1'b0;
        anc_e = 1'b0;
        pc    = '0;
        sc    = '0;
`ifdef SME_WILDCARD_EN
        anc_s = (plen > 0) && (pat_q[0] == CH_CARET);
        anc_e = (plen > int'(anc_s)) && (pat_q[PI_W'(plen - 1)] == CH_DOLLAR);
`endif
        blen = plen - int'(anc_s) - int'(anc_e);
        hit  = (cand + blen <= slen);
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < blen && cand + i < STR_MAX) begin
                pc = pat_q[PI_W'(i + int'(anc_s))];
                sc = str_q[IDX_W'(cand + i)];
`ifdef SME_WILDCARD_EN
                if (pc != sc && pc != CH_DOT) hit = 1'b0;
`else
                if (pc != sc) hit = 1'b0;
`endif
            end
        end
`ifdef SME_WILDCARD_EN
        if (anc_s && cand != 0 && str_q[IDX_W'(cand - 1)] != CH_SPACE) hit = 1'b0;
        if (anc_e && cand + blen != slen && str_q[IDX_W'(cand + blen)] != CH_SPACE) hit = 1'b0;
`endif
        exhausted = !hit && (cand + blen >= slen);
    end

    always_comb begin
        state_d   = state_q;
        str_d     = str_q;
        str_len_d = str_len_q;
        pat_d     = pat_q;
        pat_len_d = pat_len_q;
        s_d       = s_q;
        valid_d   = 1'b0;
        match_d   = match_q;
        idx_d     = idx_q;
        if (bus.isstring) begin
            state_d = LOAD_STR;
            if (!isstring_q) begin
                str_d[0]  = bus.chardata;
                str_len_d = SL_W'(1);
            end else if (int'(str_len_q) < STR_MAX) begin
                str_d[IDX_W'(str_len_q)] = bus.chardata;
                str_len_d                = str_len_q + SL_W'(1);
            end
        end else if (bus.ispattern) begin
            state_d = LOAD_PAT;
            if (!ispattern_q) begin
                pat_d[0]  = bus.chardata;
                pat_len_d = PL_W'(1);
            end else if (int'(pat_len_q) < PAT_MAX) begin
                pat_d[PI_W'(pat_len_q)] = bus.chardata;
                pat_len_d               = pat_len_q + PL_W'(1);
            end
        end else begin
            case (state_q)
                LOAD_PAT, SEARCH: begin
                    if (hit) begin
                        valid_d = 1'b1;
                        match_d = 1'b1;
                        idx_d   = IDX_W'(cand);
                        state_d = DONE;
                    end else if (exhausted) begin
                        valid_d = 1'b1;
                        match_d = 1'b0;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        s_d     = SL_W'(cand + 1);
                        state_d = SEARCH;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < STR_MAX; i++) str_q[i] <= '0;
            for (int i = 0; i < PAT_MAX; i++) pat_q[i] <= '0;
            str_len_q   <= '0;
            pat_len_q   <= '0;
            s_q         <= '0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            str_q       <= str_d;
            pat_q       <= pat_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            s_q         <= s_d;
            isstring_q  <= bus.isstring;
            ispattern_q <= bus.ispattern;
            valid_q     <= valid_d;
            match_q     <= match_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.valid       = valid_q;
    assign bus.match       = match_q;
    assign bus.match_index = idx_q;
endmodule
